// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multipliers.
// State encoding, width derivation and digit decoding.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic x_sel;
        logic x2_sel;
        logic neg;
    } digit_t;

    // Extended operand width: room for sign of unsigned operands.
    function automatic int wx_of(input int w);
        return w + 2;
    endfunction

    // Number of radix-4 digits covering the extended multiplier.
    function automatic int nd_of(input int w);
        return w / 2 + 1;
    endfunction

    // Decode y bits {2i+1, 2i, 2i-1} into select/negate controls.
    function automatic digit_t booth_dec(input logic [2:0] d);
        digit_t r;
        r.x_sel  = d[1] ^ d[0];
        r.x2_sel = (d[2] & ~d[1] & ~d[0]) | (~d[2] & d[1] & d[0]);
        r.neg    = d[2];
        return r;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Booth partial-product generator.
// Selects 0, x or 2x and conditionally negates it.
module booth_pp_gen #(
    parameter int WX = 18
) (
    input  logic [WX-1:0] x,
    input  logic          x_sel,
    input  logic          x2_sel,
    input  logic          neg,
    output logic [WX:0]   pp
);

    logic [WX:0] mag;

    // Magnitude select then one's complement plus carry-in.
    always_comb begin
        mag = ({x[WX-1], x} & {(WX+1){x_sel}})
            | ({x, 1'b0} & {(WX+1){x2_sel}});
        pp  = ({(WX+1){neg}} ^ mag) + {{WX{1'b0}}, neg};
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle.
// Valid/ready on both sides; signed or unsigned per operation.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int WX = wx_of(W);
    localparam int ND = nd_of(W);
    localparam int CW = $clog2(ND + 1);
    localparam int AW = 2 * WX;

    state_t        state;
    logic [WX-1:0] x;
    logic [WX:0]   y;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [WX-1:0] ax;
    logic [WX-1:0] bx;
    digit_t        dig;
    logic [WX:0]   pp;
    logic [AW-1:0] pp_ext;
    logic [AW-1:0] acc_next;

    // Operand extension and next accumulator value.
    always_comb begin
        ax       = is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
        bx       = is_signed ? {{2{b[W-1]}}, b} : {2'b00, b};
        dig      = booth_dec(y[2:0]);
        pp_ext   = {{(AW-WX-1){pp[WX]}}, pp};
        acc_next = acc + (pp_ext << {cnt, 1'b0});
    end

    booth_pp_gen #(
        .WX(WX)
    ) u_pp (
        .x      (x),
        .x_sel  (dig.x_sel),
        .x2_sel (dig.x2_sel),
        .neg    (dig.neg),
        .pp     (pp)
    );

    // Control FSM with shift-accumulate datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= ax;
                        y        <= {bx, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    y   <= y >> 2;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ND - 1)) begin
                        p         <= acc_next[2*W-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
